// File: rtl/lsu_pkg.sv
// lsu_pkg
// Shared definitions for the data-memory load/store unit:
//   - RV32I load/store width codes (funct3)
//   - FSM state type for data_mem_lsu
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/load_formatter.sv
// load_formatter
// Combinational extraction of a byte/halfword/word from a RAM read word,
// with sign (B/H) or zero (BU/HU) extension.
// Ports:
//   douta_i  [31:0] raw RAM read word
//   offset_i [1:0]  byte offset of the access within the word
//   funct3_i [2:0]  RV32I load width code
//   rdata_o  [31:0] right-aligned, extended load data
module load_formatter
    import lsu_pkg::*;
(
    input  logic [31:0] douta_i,
    input  logic [1:0]  offset_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] rdata_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (offset_i)
            2'd0:    byte_sel = douta_i[7:0];
            2'd1:    byte_sel = douta_i[15:8];
            2'd2:    byte_sel = douta_i[23:16];
            default: byte_sel = douta_i[31:24];
        endcase
        half_sel = offset_i[1] ? douta_i[31:16] : douta_i[15:0];
    end

    always_comb begin
        case (funct3_i)
            F3_B:    rdata_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   rdata_o = {24'd0, byte_sel};
            F3_H:    rdata_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   rdata_o = {16'd0, half_sel};
            default: rdata_o = douta_i;
        endcase
    end

endmodule

// File: rtl/data_mem_lsu.sv
// data_mem_lsu
// Load/store unit in front of a 32-bit synchronous data RAM (1-cycle read).
// Generates byte enables and lane-replicated write data for stores, returns
// extended load data two cycles after accept, and flags misaligned or
// illegal-width accesses without touching the RAM.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no response pending, ready for a request
// LOAD  | read issued, RAM data arriving this cycle; not ready
// RESP  | response pulse on resp_valid_o; ready for the next request
//
// Ports:
//   clk_i, rst_ni           clock, async active-low reset
//   req_valid_i/req_ready_o request handshake
//   req_we_i                1 = store, 0 = load
//   req_funct3_i [2:0]      width code (B/H/W/BU/HU)
//   req_addr_i   [31:0]     byte address
//   req_wdata_i  [31:0]     right-aligned store data
//   resp_valid_o            one-cycle completion pulse
//   resp_rdata_o [31:0]     extended load data (0 for stores/errors)
//   resp_err_o              misaligned/illegal access
//   wea_o [3:0], addra_o [29:0], dina_o [31:0], douta_i [31:0]  RAM port
module data_mem_lsu
    import lsu_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        resp_valid_o,
    output logic [31:0] resp_rdata_o,
    output logic        resp_err_o,
    output logic [3:0]  wea_o,
    output logic [29:0] addra_o,
    output logic [31:0] dina_o,
    input  logic [31:0] douta_i
);

    lsu_state_t  state_q, state_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        accept;
    logic        legal;
    logic [3:0]  store_be;
    logic [31:0] load_data;

    assign req_ready_o = (state_q != LOAD);
    assign accept      = req_valid_i & req_ready_o;

    // Legality of the request; BU/HU only make sense as loads.
    always_comb begin
        case (req_funct3_i)
            F3_B:    legal = 1'b1;
            F3_H:    legal = ~req_addr_i[0];
            F3_W:    legal = (req_addr_i[1:0] == 2'b00);
            F3_BU:   legal = ~req_we_i;
            F3_HU:   legal = ~req_we_i & ~req_addr_i[0];
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        case (req_funct3_i)
            F3_B: begin
                store_be = 4'b0001 << req_addr_i[1:0];
                dina_o   = {4{req_wdata_i[7:0]}};
            end
            F3_H: begin
                store_be = req_addr_i[1] ? 4'b1100 : 4'b0011;
                dina_o   = {2{req_wdata_i[15:0]}};
            end
            default: begin
                store_be = 4'b1111;
                dina_o   = req_wdata_i;
            end
        endcase
    end

    // Gating with rst_ni keeps the RAM untouched while reset is held, even
    // if the upstream stage is still presenting a store.
    assign wea_o   = (accept & req_we_i & legal & rst_ni) ? store_be : 4'b0000;
    assign addra_o = req_addr_i[31:2];

    load_formatter u_fmt (
        .douta_i  (douta_i),
        .offset_i (off_q),
        .funct3_i (f3_q),
        .rdata_o  (load_data)
    );

    always_comb begin
        state_d      = state_q;
        off_d        = off_q;
        f3_d         = f3_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'd0;
        case (state_q)
            IDLE, RESP: begin
                if (accept) begin
                    if (legal && !req_we_i) begin
                        state_d = LOAD;
                        off_d   = req_addr_i[1:0];
                        f3_d    = req_funct3_i;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = ~legal;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            off_q        <= 2'd0;
            f3_q         <= 3'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
        end else begin
            state_q      <= state_d;
            off_q        <= off_d;
            f3_q         <= f3_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign resp_valid_o = resp_valid_q;
    assign resp_err_o   = resp_err_q;
    assign resp_rdata_o = resp_rdata_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
module tb_data_mem_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [3:0]  wea;
    logic [29:0] addra;
    logic [31:0] dina;
    logic [31:0] douta = 32'd0;

    always #5 clk = ~clk;

    data_mem_lsu dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_funct3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .wea_o        (wea),
        .addra_o      (addra),
        .dina_o       (dina),
        .douta_i      (douta)
    );

    // Data RAM: 256 words, synchronous read, byte writes; outside range reads 0.
    logic [31:0] ram [256];
    initial for (int i = 0; i < 256; i++) ram[i] = 32'd0;
    always @(posedge clk) begin
        if (addra < 30'd256) begin
            for (int b = 0; b < 4; b++)
                if (wea[b]) ram[addra[7:0]][8*b +: 8] <= dina[8*b +: 8];
            douta <= ram[addra[7:0]];
        end else begin
            douta <= 32'd0;
        end
    end

    // ---------------- reference model ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int          due;
        bit          err;
        logic [31:0] rdata;
    } exp_t;
    exp_t q[$];

    logic [31:0] shadow [256];
    initial for (int i = 0; i < 256; i++) shadow[i] = 32'd0;

    function automatic bit is_legal(input bit we, input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'b000: return 1;
            3'b001: return a[0] == 1'b0;
            3'b010: return a[1:0] == 2'b00;
            3'b100: return !we;
            3'b101: return !we && a[0] == 1'b0;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        if (a[31:2] < 30'd256) return shadow[a[9:2]];
        return 32'd0;
    endfunction

    function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] w;
        int unsigned sh, v;
        w  = mem_read(a);
        sh = 8 * a[1:0];
        case (f3)
            3'b000: begin v = (w >> sh) & 32'hFF;   if (v >= 128)   v = v + 32'hFFFFFF00; end
            3'b100:       v = (w >> sh) & 32'hFF;
            3'b001: begin v = (w >> sh) & 32'hFFFF; if (v >= 32768) v = v + 32'hFFFF0000; end
            3'b101:       v = (w >> sh) & 32'hFFFF;
            default:      v = w;
        endcase
        return v;
    endfunction

    int          cyc = 0;
    bit          load_prev = 0;
    int          resp_count = 0;
    int          ready_low = 0;
    logic [31:0] last_rdata, last_dina;
    logic [29:0] last_addra;
    logic [3:0]  last_wea;
    bit          last_err;
    int          last_acc_cyc, last_resp_cyc;

    always @(negedge clk) begin
        logic [3:0]  ewea;
        logic [31:0] edin;
        bit          acc, lg;
        cyc++;
        if (!rst_n) begin
            chk("rst_wea", {28'd0, wea}, 32'd0);
            chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
            q.delete();
            load_prev = 0;
        end else begin
            // response side
            if (q.size() > 0 && q[0].due == cyc) begin
                chk("resp_valid", {31'd0, resp_valid}, 32'd1);
                chk("resp_rdata", resp_rdata, q[0].rdata);
                chk("resp_err", {31'd0, resp_err}, {31'd0, q[0].err});
                last_rdata    = resp_rdata;
                last_err      = resp_err;
                last_resp_cyc = cyc;
                resp_count++;
                q.pop_front();
            end else begin
                chk("resp_valid_idle", {31'd0, resp_valid}, 32'd0);
            end
            // request side
            chk("req_ready", {31'd0, req_ready}, {31'd0, !load_prev});
            if (!req_ready) ready_low++;
            acc = req_valid && !load_prev;
            load_prev = 0;
            if (acc) begin
                lg   = is_legal(req_we, req_funct3, req_addr);
                ewea = 4'b0000;
                edin = req_wdata;
                if (lg && req_we) begin
                    case (req_funct3)
                        3'b000: begin ewea = 4'b0001 << req_addr[1:0]; edin = {4{req_wdata[7:0]}}; end
                        3'b001: begin ewea = req_addr[1] ? 4'b1100 : 4'b0011; edin = {2{req_wdata[15:0]}}; end
                        default: ewea = 4'b1111;
                    endcase
                    chk("dina", dina, edin);
                    if (req_addr[31:2] < 30'd256)
                        for (int b = 0; b < 4; b++)
                            if (ewea[b]) shadow[req_addr[9:2]][8*b +: 8] = edin[8*b +: 8];
                end
                chk("wea", {28'd0, wea}, {28'd0, ewea});
                chk("addra", {2'd0, addra}, {2'd0, req_addr[31:2]});
                last_wea     = wea;
                last_dina    = dina;
                last_addra   = addra;
                last_acc_cyc = cyc;
                if (lg && !req_we) begin
                    q.push_back('{due: cyc + 2, err: 0, rdata: load_value(req_funct3, req_addr)});
                    load_prev = 1;
                end else begin
                    q.push_back('{due: cyc + 1, err: !lg, rdata: 32'd0});
                end
            end else begin
                chk("wea_noacc", {28'd0, wea}, 32'd0);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bit ok;
        ok = 0;
        req_valid = 1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = d;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (req_ready === 1'b1) begin ok = 1; break; end
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL issue_timeout: req_ready stuck at %b, required 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 0;
    endtask

    task automatic txn(input bit we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        int  c0;
        bit  ok;
        c0 = resp_count;
        ok = 0;
        issue(we, f3, a, d);
        for (int i = 0; i < 6; i++) begin
            if (resp_count != c0) begin ok = 1; break; end
            @(negedge clk); #1;
        end
        if (!ok) begin
            n_cmp++; n_err++;
            $display("FAIL resp_timeout: got %0d responses, required %0d", resp_count - c0, 1);
        end
        @(posedge clk); #1;
    endtask

    task automatic cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, r0;
        logic [31:0] a, d;
        logic [2:0]  f3;
        bit          we;

        cycles(3);
        chk("reset_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset_resp_err", {31'd0, resp_err}, 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'd0);
        chk("reset_req_ready", {31'd0, req_ready}, 32'd1);
        rst_n = 1;
        cycles(2);

        // SW then LW
        txn(1, 3'b010, 32'h100, 32'hDEADBEEF);
        chk("sw_wea", {28'd0, last_wea}, 32'hF);
        chk("sw_addra", {2'd0, last_addra}, 32'h40);
        chk("sw_latency", last_resp_cyc - last_acc_cyc, 1);
        txn(0, 3'b010, 32'h100, 32'd0);
        chk("lw_data", last_rdata, 32'hDEADBEEF);
        chk("lw_latency", last_resp_cyc - last_acc_cyc, 2);

        // SB into lane 1
        txn(1, 3'b000, 32'h101, 32'h123456AB);
        chk("sb_wea", {28'd0, last_wea}, 32'h2);
        chk("sb_dina", last_dina, 32'hABABABAB);
        txn(0, 3'b010, 32'h100, 32'd0);
        chk("sb_readback", last_rdata, 32'hDEADABEF);

        // Extension cases
        txn(1, 3'b010, 32'h200, 32'h00008080);
        txn(0, 3'b000, 32'h200, 32'd0); chk("lb", last_rdata, 32'hFFFFFF80);
        txn(0, 3'b100, 32'h200, 32'd0); chk("lbu", last_rdata, 32'h00000080);
        txn(0, 3'b001, 32'h200, 32'd0); chk("lh", last_rdata, 32'hFFFF8080);
        txn(0, 3'b101, 32'h200, 32'd0); chk("lhu", last_rdata, 32'h00008080);

        // Misaligned accesses
        txn(0, 3'b010, 32'h102, 32'd0);
        chk("lw_mis_err", {31'd0, last_err}, 32'd1);
        chk("lw_mis_rdata", last_rdata, 32'd0);
        txn(1, 3'b001, 32'h203, 32'hFFFFFFFF);
        chk("sh_mis_err", {31'd0, last_err}, 32'd1);
        chk("sh_mis_wea", {28'd0, last_wea}, 32'd0);
        txn(0, 3'b010, 32'h100, 32'd0); chk("mis_readback0", last_rdata, 32'hDEADABEF);
        txn(0, 3'b010, 32'h200, 32'd0); chk("mis_readback1", last_rdata, 32'h00008080);

        // Back-to-back stores
        c0 = resp_count; r0 = ready_low;
        issue(1, 3'b010, 32'h300, 32'h11111111);
        issue(1, 3'b010, 32'h304, 32'h22222222);
        issue(1, 3'b010, 32'h308, 32'h33333333);
        cycles(1);
        chk("b2b_resp_count", resp_count - c0, 3);
        chk("b2b_ready_low", ready_low - r0, 0);

        // Load followed by store
        r0 = ready_low;
        issue(0, 3'b010, 32'h300, 32'd0);
        issue(1, 3'b010, 32'h30C, 32'h44444444);
        cycles(2);
        chk("ld_st_ready_low", ready_low - r0, 1);

        // Reset while in LOAD
        issue(0, 3'b010, 32'h100, 32'd0);
        rst_n = 0;
        c0 = resp_count;
        cycles(2);
        rst_n = 1;
        cycles(4);
        chk("rst_load_no_resp", resp_count - c0, 0);
        chk("rst_load_ready", {31'd0, req_ready}, 32'd1);
        txn(0, 3'b010, 32'h100, 32'd0);
        chk("post_rst_lw", last_rdata, 32'hDEADABEF);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            we = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                case ($urandom_range(0, 4))
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    default: f3 = 3'b101;
                endcase
            end else begin
                f3 = 3'($urandom_range(0, 7));
            end
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 9) == 0) a[31] = 1'b1;
            d = $urandom;
            issue(we, f3, a, d);
            cycles($urandom_range(0, 2));
        end
        cycles(5);
        chk("drain", q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Load/store unit sitting directly upstream of the data RAM: accepts one load or store request per handshake from the execute/memory stage and drives the RAM port (`wea`, `addra`, `dina`). It generates byte enables and replicates byte/halfword write data across lanes. It absorbs the RAM's one-cycle synchronous read latency and returns sign- or zero-extended load data with a valid pulse. Misaligned and illegal-width accesses are flagged and never reach the RAM.

## Interface
- No parameters. Data RAM is fixed at 32-bit words with 4 byte lanes and a word address of `[31:2]`.
- `clk` in 1: single clock; all state updates on posedge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: unit can accept a request this cycle.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU are loads only).
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out 32: extended load data. It is 0 for stores and errors.
- `resp_err` out 1: misaligned or illegal access; qualified by `resp_valid`.
- `wea` out 4: RAM byte write enables.
- `addra` out 30: RAM word address, `req_addr[31:2]`.
- `dina` out 32: RAM write data, lane-replicated.
- `douta` in 32: RAM read data, valid the cycle after `addra` is sampled.

## Operation
- Each request falls into one of three cases:
  - Load: starts a read and returns data later.
  - Store: writes immediately and returns no data.
  - Error: touches no RAM.
- FSM states are `IDLE`, `LOAD`, `RESP`.
  - `req_ready` = 1 in `IDLE` and `RESP`, 0 in `LOAD`.
  - Accept = `req_valid & req_ready`.
- Transitions:
  - Accept of a legal load goes to `LOAD`.
  - Accept of a store or error goes to `RESP`.
  - `LOAD` always goes to `RESP`.
  - `RESP` with no accept goes to `IDLE`. `RESP` with an accept follows the same rules as `IDLE`.
- RAM port is combinational from the request, gated by accept and `rst_n`.
  - `addra` = `req_addr[31:2]`.
  - `wea` is non-zero only on accept of a legal store, otherwise 4'b0000.
- Store lane rules:
  - SB: `wea` = 4'b0001 << `addr[1:0]`; `dina` = {4{`wdata[7:0]`}}.
  - SH: `wea` = `addr[1]` ? 4'b1100 : 4'b0011; `dina` = {2{`wdata[15:0]`}}.
  - SW: `wea` = 4'b1111; `dina` = `wdata`.
- Error conditions:
  - H/HU with `addr[0]`=1.
  - W with `addr[1:0]`≠0.
  - funct3 ∈ {011, 110, 111}.
  - Stores with funct3 BU/HU.
- Error response: `wea`=0, `resp_err`=1, `resp_rdata`=0.
- Load extraction:
  - `addr[1:0]` and funct3 are registered at accept.
  - In `LOAD`, the selected byte/half of `douta` is sign- (B/H) or zero- (BU/HU) extended, then registered into `resp_rdata`.
- Out-of-range addresses are not errors; the RAM returns 0.

## Timing
- Reset values:
  - FSM = `IDLE`.
  - `resp_valid`=0, `resp_err`=0, `resp_rdata`=0.
  - `wea`=0 while `rst_n`=0.
- Store or error: accept at edge E0; `resp_valid`=1 in the cycle after E0. Stores sustain 1 per cycle.
- Load: accept at E0 (RAM samples the address at E0) → `douta` valid after E0 → formatted data registered at E1 → `resp_valid`=1 after E1. Latency is 2 cycles; loads sustain 1 per 2 cycles.
- `resp_valid` is a single-cycle pulse per request; responses are in order.
- A new accept in `RESP` overlaps that response pulse and does not delay it.
- Reset asserted in `LOAD` drops the outstanding load: no `resp_valid` after release, and the FSM is in `IDLE`.
- `req_*` need only be stable in the accept cycle.

## Structure
- Package `lsu_pkg` holds:
  - funct3 constants `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - FSM state enum `lsu_state_t`.
- Sub-module `load_formatter` is combinational. It takes `douta`, `addr[1:0]` and funct3, and returns the 32-bit extended value. It is used only by this block.

## Test plan
- SW 0xDEADBEEF @0x100, then LW @0x100: `wea`=1111, `addra`=0x40; `resp_rdata`=0xDEADBEEF two cycles after the load accept.
- SB 0xAB @0x101 over the 0xDEADBEEF word: `wea`=0010, `dina`=0xABABABAB; a following LW @0x100 returns 0xDEADABEF.
- With word 0x00008080 @0x200: LB @0x200 → 0xFFFFFF80; LBU @0x200 → 0x00000080; LH @0x200 → 0xFFFF8080; LHU @0x200 → 0x00008080.
- LW @0x102 and SH @0x203: `wea`=0 throughout, `resp_err`=1, `resp_rdata`=0, and memory is unchanged on readback.
- Three back-to-back stores (`req_valid` held): three consecutive `resp_valid` pulses with `req_ready`=1 throughout. A load followed by a store: `req_ready`=0 for exactly one cycle.
- Pull `rst_n` low in `LOAD`: no `resp_valid` after release, `req_ready`=1, and the next LW completes normally.
